// File: rtl/armleocpu_ptw.sv
// Sv32 page table walker: resolves a VPN to a 4 KiB-granule PPN plus the leaf PTE access bits,
// reporting malformed PTEs as page faults and memory errors as access faults.
`timescale 1ns/1ps
module armleocpu_ptw (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resolve_request,
  input  logic [19:0] resolve_virtual_address,
  input  logic [21:0] satp_ppn,
  output logic        resolve_busy,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [21:0] resolve_physical_address,
  output logic [7:0]  resolve_access_bits,
  output logic        mem_read,
  output logic [33:0] mem_address,
  input  logic        mem_ack,
  input  logic [31:0] mem_readdata,
  input  logic        mem_accessfault
);

  typedef enum logic {
    STATE_IDLE,
    STATE_WALK
  } state_t;

  state_t      state_q, state_d;
  logic        level_q, level_d;
  logic [9:0]  vpn0_q, vpn0_d;
  logic [33:0] mem_address_q, mem_address_d;
  logic        done_q, done_d;
  logic        pagefault_q, pagefault_d;
  logic        accessfault_q, accessfault_d;
  logic [21:0] pa_q, pa_d;
  logic [7:0]  bits_q, bits_d;

  logic pte_valid, pte_read, pte_write, pte_exec;
  logic pte_leaf, pte_malformed, pte_misaligned;

  assign pte_valid      = mem_readdata[0];
  assign pte_read       = mem_readdata[1];
  assign pte_write      = mem_readdata[2];
  assign pte_exec       = mem_readdata[3];
  assign pte_leaf       = pte_read | pte_exec;
  assign pte_malformed  = !pte_valid || (pte_write && !pte_read);
  assign pte_misaligned = level_q && (mem_readdata[19:10] != 10'd0);

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    vpn0_d        = vpn0_q;
    mem_address_d = mem_address_q;
    done_d        = 1'b0;
    pagefault_d   = pagefault_q;
    accessfault_d = accessfault_q;
    pa_d          = pa_q;
    bits_d        = bits_q;

    case (state_q)
      STATE_IDLE: begin
        if (resolve_request) begin
          vpn0_d        = resolve_virtual_address[9:0];
          mem_address_d = {satp_ppn, resolve_virtual_address[19:10], 2'b00};
          level_d       = 1'b1;
          state_d       = STATE_WALK;
        end
      end
      STATE_WALK: begin
        if (mem_ack) begin
          // Every terminating outcome clears the result first; only a good leaf fills it in.
          done_d        = 1'b1;
          state_d       = STATE_IDLE;
          pagefault_d   = 1'b0;
          accessfault_d = 1'b0;
          pa_d          = 22'd0;
          bits_d        = 8'd0;
          if (mem_accessfault) begin
            accessfault_d = 1'b1;
          end else if (pte_malformed) begin
            pagefault_d = 1'b1;
          end else if (pte_leaf) begin
            if (pte_misaligned) begin
              pagefault_d = 1'b1;
            end else begin
              pa_d   = level_q ? {mem_readdata[31:20], vpn0_q} : mem_readdata[31:10];
              bits_d = mem_readdata[7:0];
            end
          end else if (!level_q) begin
            pagefault_d = 1'b1;
          end else begin
            // Pointer from the root table: descend without reporting anything.
            done_d        = 1'b0;
            state_d       = STATE_WALK;
            pagefault_d   = pagefault_q;
            accessfault_d = accessfault_q;
            pa_d          = pa_q;
            bits_d        = bits_q;
            level_d       = 1'b0;
            mem_address_d = {mem_readdata[31:10], vpn0_q, 2'b00};
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= STATE_IDLE;
      level_q       <= 1'b1;
      vpn0_q        <= 10'd0;
      mem_address_q <= 34'd0;
      done_q        <= 1'b0;
      pagefault_q   <= 1'b0;
      accessfault_q <= 1'b0;
      pa_q          <= 22'd0;
      bits_q        <= 8'd0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      vpn0_q        <= vpn0_d;
      mem_address_q <= mem_address_d;
      done_q        <= done_d;
      pagefault_q   <= pagefault_d;
      accessfault_q <= accessfault_d;
      pa_q          <= pa_d;
      bits_q        <= bits_d;
    end
  end

  assign resolve_busy             = (state_q != STATE_IDLE);
  assign mem_read                 = (state_q == STATE_WALK);
  assign mem_address              = mem_address_q;
  assign resolve_done             = done_q;
  assign resolve_pagefault        = pagefault_q;
  assign resolve_accessfault      = accessfault_q;
  assign resolve_physical_address = pa_q;
  assign resolve_access_bits      = bits_q;

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Scoreboard bench for armleocpu_ptw: a sparse page-table memory, a walk model evaluated when
// each request is issued, a memory responder that checks addresses, and a done-pulse monitor.
`timescale 1ns/1ps
module tb_armleocpu_ptw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        resolve_request = 1'b0;
  logic [19:0] resolve_virtual_address = 20'd0;
  logic [21:0] satp_ppn = 22'd0;
  logic        resolve_busy, resolve_done, resolve_pagefault, resolve_accessfault;
  logic [21:0] resolve_physical_address;
  logic [7:0]  resolve_access_bits;
  logic        mem_read;
  logic [33:0] mem_address;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_readdata = 32'd0;
  logic        mem_accessfault = 1'b0;

  armleocpu_ptw dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .resolve_request          (resolve_request),
    .resolve_virtual_address  (resolve_virtual_address),
    .satp_ppn                 (satp_ppn),
    .resolve_busy             (resolve_busy),
    .resolve_done             (resolve_done),
    .resolve_pagefault        (resolve_pagefault),
    .resolve_accessfault      (resolve_accessfault),
    .resolve_physical_address (resolve_physical_address),
    .resolve_access_bits      (resolve_access_bits),
    .mem_read                 (mem_read),
    .mem_address              (mem_address),
    .mem_ack                  (mem_ack),
    .mem_readdata             (mem_readdata),
    .mem_accessfault          (mem_accessfault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] pa;
    logic [7:0]  bits;
    logic        pf;
    logic        af;
    int          lat;
    int          req_cycle;
  } res_t;

  res_t        exp_res_q[$];
  logic [33:0] exp_addr_q[$];
  bit [31:0]   mem_data [bit [33:0]];
  bit          mem_err  [bit [33:0]];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int done_count = 0;
  int issued = 0;
  bit force_ack = 1'b0;
  bit prev_done = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name, input logic [63:0] actual);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0h expected none", name, actual);
  endtask

  // Reference walk: follows the Sv32 rules over the sparse memory with plain arithmetic and
  // queues every PTE address it reads plus the final result.
  function automatic void walkModel(input logic [21:0] satp, input logic [19:0] vpn,
                                    input int delay, input int req_cycle, input bit timed);
    res_t        r;
    logic [33:0] a;
    bit [31:0]   pte;
    int          level = 1;
    int          reads = 0;
    bit          fin = 1'b0;
    longint      vpn1 = longint'(vpn) / 1024;
    longint      vpn0 = longint'(vpn) % 1024;
    r = '{pa: 22'd0, bits: 8'd0, pf: 1'b0, af: 1'b0, lat: -1, req_cycle: req_cycle};
    a = 34'(satp) * 34'd4096 + 34'(vpn1 * 4);
    while (!fin) begin
      exp_addr_q.push_back(a);
      reads++;
      pte = mem_data.exists(a) ? mem_data[a] : 32'd0;
      fin = 1'b1;
      if (mem_err.exists(a) && mem_err[a]) begin
        r.af = 1'b1;
      end else if ((pte % 2) == 0 || (pte[2] && !pte[1])) begin
        r.pf = 1'b1;
      end else if (pte[1] || pte[3]) begin
        if (level == 1 && ((pte / 1024) % 1024) != 0) begin
          r.pf = 1'b1;
        end else if (level == 1) begin
          r.pa   = 22'((longint'(pte) / (1 << 20)) * 1024 + vpn0);
          r.bits = 8'(pte % 256);
        end else begin
          r.pa   = 22'(pte / 1024);
          r.bits = 8'(pte % 256);
        end
      end else if (level == 0) begin
        r.pf = 1'b1;
      end else begin
        level = 0;
        a = 34'(pte / 1024) * 34'd4096 + 34'(vpn0 * 4);
        fin = 1'b0;
      end
    end
    if (timed) r.lat = 1 + reads * (delay + 1);
    exp_res_q.push_back(r);
  endfunction

  // Memory responder: checks each presented PTE address against the model and acks after
  // ack_delay idle cycles; force_ack injects a stray ack for the post-reset test.
  initial forever begin
    @(negedge clk);
    mem_ack = 1'b0;
    mem_accessfault = 1'b0;
    mem_readdata = 32'd0;
    if (force_ack) begin
      mem_ack = 1'b1;
      mem_readdata = 32'h00002001;
    end else if (mem_read) begin
      if (exp_addr_q.size() == 0) failNow("unexpected_read", {30'd0, mem_address});
      else checkOutput("mem_address", {30'd0, mem_address}, {30'd0, exp_addr_q[0]});
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        mem_readdata = mem_data.exists(mem_address) ? mem_data[mem_address] : 32'd0;
        mem_accessfault = mem_err.exists(mem_address) ? mem_err[mem_address] : 1'b0;
        if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Done monitor: pops the scoreboard on every done pulse and compares all result fields.
  initial forever begin
    res_t e;
    @(negedge clk);
    if (resolve_done) begin
      done_count++;
      if (prev_done) failNow("done_width", 64'd1);
      if (exp_res_q.size() == 0) begin
        failNow("unexpected_done", {42'd0, resolve_physical_address});
      end else begin
        e = exp_res_q.pop_front();
        checkOutput("pa", {42'd0, resolve_physical_address}, {42'd0, e.pa});
        checkOutput("bits", {56'd0, resolve_access_bits}, {56'd0, e.bits});
        checkOutput("pagefault", {63'd0, resolve_pagefault}, {63'd0, e.pf});
        checkOutput("accessfault", {63'd0, resolve_accessfault}, {63'd0, e.af});
        checkOutput("busy_at_done", {63'd0, resolve_busy}, 64'd0);
        if (e.lat >= 0) checkOutput("latency", 64'(cycle - e.req_cycle), 64'(e.lat));
      end
    end
    prev_done = resolve_done;
  end

  task automatic waitIdle();
    for (int i = 0; i < 400; i++) begin
      if (!resolve_busy && exp_res_q.size() == 0 && !resolve_request) return;
      @(negedge clk);
    end
    failNow("idle_timeout", 64'(exp_res_q.size()));
  endtask

  task automatic applyStimulus(input logic [21:0] satp, input logic [19:0] vpn,
                               input int delay, input int hold);
    waitIdle();
    ack_delay = delay;
    wait_cnt = 0;
    walkModel(satp, vpn, delay, cycle, 1'b1);
    issued++;
    satp_ppn = satp;
    resolve_virtual_address = vpn;
    resolve_request = 1'b1;
    repeat (hold) @(negedge clk);
    resolve_request = 1'b0;
  endtask

  function automatic bit [31:0] genPte(input int cat, input bit root);
    bit [31:0] p = $urandom;
    case (cat)
      0: begin
        p[0] = 1'b1;
        if (!p[1] && !p[3]) p[1] = 1'b1;
        if (p[2] && !p[1]) p[1] = 1'b1;
        if (root && $urandom_range(0, 1) == 1) p[19:10] = 10'd0;
      end
      1: p[0] = 1'b0;
      2: begin p[0] = 1'b1; p[1] = 1'b0; p[2] = 1'b1; end
      default: begin p[0] = 1'b1; p[3:1] = 3'b000; end
    endcase
    return p;
  endfunction

  task automatic randomWalk();
    logic [21:0] satp = 22'($urandom);
    logic [19:0] vpn = 20'($urandom);
    logic [33:0] a1, a2;
    bit [31:0]   p1;
    int          cat1 = $urandom_range(0, 5);
    a1 = 34'(satp) * 34'd4096 + 34'(vpn / 1024) * 34'd4;
    p1 = genPte(cat1, 1'b1);
    mem_data[a1] = p1;
    mem_err[a1] = ($urandom_range(0, 9) == 0);
    if (cat1 >= 3) begin
      a2 = 34'(p1 / 1024) * 34'd4096 + 34'(vpn % 1024) * 34'd4;
      mem_data[a2] = genPte($urandom_range(0, 4), 1'b0);
      mem_err[a2] = ($urandom_range(0, 9) == 0);
    end
    applyStimulus(satp, vpn, $urandom_range(0, 3), 1);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {63'd0, resolve_busy}, 64'd0);
    checkOutput("rst_done", {63'd0, resolve_done}, 64'd0);
    checkOutput("rst_pf", {63'd0, resolve_pagefault}, 64'd0);
    checkOutput("rst_af", {63'd0, resolve_accessfault}, 64'd0);
    checkOutput("rst_pa", {42'd0, resolve_physical_address}, 64'd0);
    checkOutput("rst_bits", {56'd0, resolve_access_bits}, 64'd0);
    checkOutput("rst_mem_read", {63'd0, mem_read}, 64'd0);
    checkOutput("rst_mem_address", {30'd0, mem_address}, 64'd0);
    rst_n = 1'b1;

    // Single-level megapage, two-level page, then the malformed-PTE cases.
    mem_data[34'h1004] = 32'h123000CF;
    applyStimulus(22'h1, 20'h00401, 0, 1);
    waitIdle();
    mem_data[34'h1004] = 32'h00002001;
    mem_data[34'h8004] = 32'h0ABCD0DB;
    applyStimulus(22'h1, 20'h00401, 0, 1);
    waitIdle();
    mem_data[34'h1004] = 32'h000004CF;
    applyStimulus(22'h1, 20'h00401, 0, 1);
    waitIdle();
    mem_data[34'h1004] = 32'h000000C5;
    applyStimulus(22'h1, 20'h00401, 1, 1);
    waitIdle();
    mem_data[34'h1004] = 32'h00000000;
    applyStimulus(22'h1, 20'h00401, 0, 1);
    waitIdle();
    mem_data[34'h1004] = 32'h00002001;
    mem_data[34'h8004] = 32'h00003001;
    applyStimulus(22'h1, 20'h00401, 0, 1);
    waitIdle();
    mem_err[34'h1004] = 1'b1;
    applyStimulus(22'h1, 20'h00401, 5, 1);
    waitIdle();
    mem_err[34'h1004] = 1'b0;

    // Reset while a read is outstanding, then a stray ack that must be ignored.
    mem_data[34'h1004] = 32'h123000CF;
    applyStimulus(22'h1, 20'h00401, 20, 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_mem_read", {63'd0, mem_read}, 64'd0);
    checkOutput("reset_busy", {63'd0, resolve_busy}, 64'd0);
    exp_res_q.delete();
    exp_addr_q.delete();
    issued--;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cnt = 0;
    @(posedge clk);
    #1 force_ack = 1'b1;
    @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    checkOutput("late_ack_busy", {63'd0, resolve_busy}, 64'd0);
    checkOutput("late_ack_mem_read", {63'd0, mem_read}, 64'd0);
    applyStimulus(22'h1, 20'h00401, 0, 1);
    waitIdle();

    // Request held while busy yields a single walk.
    base = done_count;
    applyStimulus(22'h1, 20'h00401, 4, 3);
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("busy_request_dones", 64'(done_count - base), 64'd1);

    // Request held through the done cycle starts a second walk back-to-back.
    base = done_count;
    ack_delay = 0;
    wait_cnt = 0;
    walkModel(22'h1, 20'h00401, 0, cycle, 1'b0);
    walkModel(22'h1, 20'h00401, 0, cycle, 1'b0);
    issued += 2;
    satp_ppn = 22'h1;
    resolve_virtual_address = 20'h00401;
    resolve_request = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        if (resolve_done) seen = 1'b1;
      end
      if (!seen) failNow("b2b_timeout", 64'd0);
    end
    @(posedge clk);
    #1 resolve_request = 1'b0;
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("b2b_dones", 64'(done_count - base), 64'd2);

    for (int n = 0; n < 150; n++) randomWalk();
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("done_count", 64'(done_count), 64'(issued));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
